// File: rtl/sample_packer.sv
// Packs SAMPLE_WIDTH-bit samples, lane 0 first, into SAMPLE_WIDTH*PACK-bit words for the fifo wrapper.
// last_i flushes a partial word zero-padded; a completed word waits in din_o until the FIFO has room.
module sample_packer #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int PACK         = 4,
  localparam int CW          = (PACK > 1) ? $clog2(PACK) : 1,
  localparam int DW          = SAMPLE_WIDTH * PACK
) (
  input  logic                    clk_i,
  input  logic                    rst_i_n,
  input  logic [SAMPLE_WIDTH-1:0] data_i,
  input  logic                    valid_i,
  input  logic                    last_i,
  output logic                    ready_o,
  output logic                    enq_o,
  output logic [DW-1:0]           din_o,
  input  logic                    full_i_n
);

  // Handshake: a sample moves on any rising edge where valid_i & ready_o; the producer
  // holds data_i/last_i stable while valid_i & ~ready_o. A word is written when enq_o is high.
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_acc;
  logic [DW-1:0] r_din;
  logic          r_pend;

  logic          w_accept;
  logic          w_complete;
  logic [DW-1:0] w_merged;

  assign enq_o    = r_pend & full_i_n;
  assign ready_o  = ~r_pend | full_i_n;
  assign din_o    = r_din;
  assign w_accept = valid_i & ready_o;
  assign w_complete = w_accept & ((r_cnt == CW'(PACK - 1)) | last_i);

  // Lanes above r_cnt are always zero in r_acc, so inserting the sample also zero-pads a flush.
  always_comb begin
    w_merged = r_acc;
    for (int k = 0; k < PACK; k++) begin
      if (r_cnt == CW'(k)) w_merged[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] = data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i_n) begin
    if (!rst_i_n) begin
      r_cnt  <= '0;
      r_acc  <= '0;
      r_din  <= '0;
      r_pend <= 1'b0;
    end else if (w_complete) begin
      r_din  <= w_merged;
      r_pend <= 1'b1;
      r_cnt  <= '0;
      r_acc  <= '0;
    end else begin
      if (enq_o) r_pend <= 1'b0;
      if (w_accept) begin
        r_acc <= w_merged;
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sample_packer.sv
// Bench for sample_packer: PACK=4 and PACK=1 instances share stimulus; a word-level reference
// model (sample grouping into a queue of expected words) predicts enq/ready/din every cycle.
module tb_sample_packer;

  logic        clk;
  logic        rst_n;
  logic [15:0] data;
  logic        valid;
  logic        last;
  logic        full_n;

  logic        rdy4, enq4;
  logic [63:0] din4;
  logic        rdy1, enq1;
  logic [15:0] din1;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] exp4_q[$];
  logic [15:0] exp1_q[$];
  logic [15:0] part4[$];

  sample_packer #(.SAMPLE_WIDTH(16), .PACK(4)) u_dut4 (
    .clk_i(clk), .rst_i_n(rst_n), .data_i(data), .valid_i(valid), .last_i(last),
    .ready_o(rdy4), .enq_o(enq4), .din_o(din4), .full_i_n(full_n)
  );

  sample_packer #(.SAMPLE_WIDTH(16), .PACK(1)) u_dut1 (
    .clk_i(clk), .rst_i_n(rst_n), .data_i(data), .valid_i(valid), .last_i(last),
    .ready_o(rdy1), .enq_o(enq1), .din_o(din1), .full_i_n(full_n)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // reference model: group accepted samples into words of PACK or until last
  task automatic model4_push(input logic [15:0] d, input logic l);
    logic [63:0] w;
    part4.push_back(d);
    if (part4.size() == 4 || l) begin
      w = '0;
      for (int i = 0; i < part4.size(); i++) w = w | (64'(part4[i]) << (16 * i));
      exp4_q.push_back(w);
      part4.delete();
    end
  endtask

  // driver: one clock cycle of stimulus, with checks sampled mid-low-phase
  task automatic cycle(input logic v, input logic [15:0] d, input logic l, input logic f);
    bit er4, er1;
    @(negedge clk);
    valid = v; data = d; last = l; full_n = f;
    #1;
    er4 = (exp4_q.size() == 0) || f;
    chk("enq4", {63'd0, enq4}, {63'd0, (exp4_q.size() > 0) && f});
    chk("ready4", {63'd0, rdy4}, {63'd0, er4});
    if (exp4_q.size() > 0) begin
      chk("din4", din4, exp4_q[0]);
      if (f) void'(exp4_q.pop_front());
    end
    if (v && er4) model4_push(d, l);

    er1 = (exp1_q.size() == 0) || f;
    chk("enq1", {63'd0, enq1}, {63'd0, (exp1_q.size() > 0) && f});
    chk("ready1", {63'd0, rdy1}, {63'd0, er1});
    if (exp1_q.size() > 0) begin
      chk("din1", {48'd0, din1}, {48'd0, exp1_q[0]});
      if (f) void'(exp1_q.pop_front());
    end
    if (v && er1) exp1_q.push_back(d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; valid = 1'b0; last = 1'b0;
    #1;
    chk("rst_enq4", {63'd0, enq4}, 64'd0);
    chk("rst_ready4", {63'd0, rdy4}, 64'd1);
    chk("rst_din4", din4, 64'd0);
    chk("rst_enq1", {63'd0, enq1}, 64'd0);
    chk("rst_ready1", {63'd0, rdy1}, 64'd1);
    chk("rst_din1", {48'd0, din1}, 64'd0);
    exp4_q.delete(); exp1_q.delete(); part4.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; data = '0; last = 1'b0; full_n = 1'b1;
    do_reset();

    // basic pack
    for (int i = 1; i <= 4; i++) cycle(1'b1, 16'(i), 1'b0, 1'b1);
    cycle(1'b0, 16'h0, 1'b0, 1'b1);
    chk("basic_din", din4, 64'h0004_0003_0002_0001);

    // partial flush, then next word restarts at lane 0
    cycle(1'b1, 16'h00AA, 1'b0, 1'b1);
    cycle(1'b1, 16'h00BB, 1'b1, 1'b1);
    cycle(1'b0, 16'h0, 1'b0, 1'b1);
    chk("flush_din", din4, 64'h0000_0000_00BB_00AA);
    for (int i = 0; i < 4; i++) cycle(1'b1, 16'h0C00 + 16'(i), 1'b0, 1'b1);
    cycle(1'b0, 16'h0, 1'b0, 1'b1);
    chk("lane0_din", din4, 64'h0C03_0C02_0C01_0C00);

    // backpressure: complete with FIFO full, hold 5 cycles, then release
    for (int i = 1; i <= 3; i++) cycle(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b1);
    cycle(1'b1, 16'h0104, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 16'h0105, 1'b0, 1'b0);
    chk("bp_din_held", din4, 64'h0104_0103_0102_0101);
    cycle(1'b1, 16'h0105, 1'b0, 1'b1);
    for (int i = 6; i <= 8; i++) cycle(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b1);
    cycle(1'b0, 16'h0, 1'b0, 1'b1);
    chk("bp_next_din", din4, 64'h0108_0107_0106_0105);

    // streaming
    for (int i = 0; i < 64; i++) cycle(1'b1, 16'(i), 1'b0, 1'b1);
    cycle(1'b0, 16'h0, 1'b0, 1'b1);
    chk("stream_last_din", din4, 64'h003F_003E_003D_003C);

    // reset mid-word
    cycle(1'b1, 16'h0D01, 1'b0, 1'b1);
    cycle(1'b1, 16'h0D02, 1'b0, 1'b1);
    do_reset();
    for (int i = 1; i <= 4; i++) cycle(1'b1, 16'h0E00 + 16'(i), 1'b0, 1'b1);
    cycle(1'b0, 16'h0, 1'b0, 1'b1);
    chk("post_rst_din", din4, 64'h0E04_0E03_0E02_0E01);

    // random traffic
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 3) != 0));
    for (int i = 0; i < 4; i++) cycle(1'b0, 16'h0, 1'b0, 1'b1);
    chk("drained4", 64'(exp4_q.size()), 64'd0);
    chk("drained1", 64'(exp1_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
